// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word reads to a
// one-cycle-latency instruction memory, buffers returned words in a small
// FIFO and presents {instr, pc, pc+4} to decode with a valid/ready handshake.
// A redirect from execute flushes the FIFO, drops the response in flight
// and restarts fetching at the new address in the same cycle.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [31:0]   pc;
  logic          inflight;
  logic [31:0]   inflight_pc;

  logic [31:0]   fifo_instr [DEPTH];
  logic [31:0]   fifo_pc    [DEPTH];
  logic [31:0]   fifo_pc4   [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          pop;
  logic          wr_en;
  logic [31:0]   redirect_addr;
  logic [CW:0]   pending;

  // Handshake, response acceptance and request/address generation
  always_comb begin
    redirect_addr = {redirect_pc[31:2], 2'b00};
    pop           = out_valid & out_ready & ~redirect_valid;
    wr_en         = inflight & ~redirect_valid;
    // Slots that will be occupied after this cycle, excluding a new request
    pending       = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    imem_req      = 1'b0;
    imem_addr     = pc;
    if (rst_n) begin
      if (redirect_valid) begin
        imem_req  = 1'b1;
        imem_addr = redirect_addr;
      end else begin
        imem_req  = (pending < (CW+1)'(DEPTH));
      end
    end
  end

  // Head entry is read straight from registered FIFO storage
  always_comb begin
    out_valid    = (count != '0);
    out_instr    = fifo_instr[rd_ptr];
    out_pc       = fifo_pc[rd_ptr];
    out_pc_plus4 = fifo_pc4[rd_ptr];
  end

  // Fetch PC and in-flight request tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      pc          <= redirect_addr + 32'd4;
      inflight    <= 1'b1;
      inflight_pc <= redirect_addr;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        pc          <= pc + 32'd4;
        inflight_pc <= pc;
      end
    end
  end

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
        fifo_pc4[i]   <= '0;
      end
    end else if (redirect_valid) begin
      // Flush by collapsing the write pointer onto the read pointer; the
      // stale entries stay in storage but are unreachable once count is 0.
      wr_ptr <= rd_ptr;
      count  <= '0;
    end else begin
      if (wr_en) begin
        fifo_instr[wr_ptr] <= imem_rdata;
        fifo_pc[wr_ptr]    <= inflight_pc;
        fifo_pc4[wr_ptr]   <= inflight_pc + 32'd4;
        wr_ptr             <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(wr_en) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit. The expected delivery stream is a
// run of consecutive word addresses starting at the reset PC or the latest
// redirect target; the memory model returns an address-derived word.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_pc_plus4(out_pc_plus4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_3C5A;
  endfunction

  int compared = 0;
  int mismatched = 0;
  int delivered = 0;

  logic [31:0] exp_q [$];
  logic [31:0] next_push = RESET_PC;
  logic        pend_valid = 1'b0;
  logic [31:0] pend_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic restart(input logic [31:0] a);
    exp_q.delete();
    next_push = a;
  endtask

  task automatic topup();
    while (exp_q.size() < 8) begin
      exp_q.push_back(next_push);
      next_push = next_push + 32'd4;
    end
  endtask

  // One cycle of stimulus, applied just after the rising edge
  task automatic drive(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    rst_n          = rst;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_rdata     = pend_valid ? word_of(pend_addr) : $urandom();
    if (!rst) restart(RESET_PC);
    else if (rv) restart({rpc[31:2], 2'b00});
    topup();
  endtask

  // Monitor: samples mid-cycle, pops the scoreboard on each handshake
  initial begin : monitor
    logic pv, prdy, pr, r1, r2, cur_pop;
    logic [31:0] ppc, pins, t1, t2, e;
    int stall_run, since_rst;
    pv = 0; prdy = 0; pr = 0; r1 = 0; r2 = 0;
    ppc = '0; pins = '0; t1 = '0; t2 = '0;
    stall_run = 0; since_rst = -1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_pc4", out_pc_plus4, 32'd0);
        pend_valid = 0; pv = 0; r1 = 0; r2 = 0; pr = 0;
        stall_run = 0; since_rst = -1;
      end else begin
        since_rst++;
        cur_pop = out_valid & out_ready & ~redirect_valid;
        if (imem_req) chk("addr_align", 32'(imem_addr[1:0]), 32'd0);
        if (redirect_valid) begin
          chk("redir_req", 32'(imem_req), 32'd1);
          chk("redir_addr", imem_addr, {redirect_pc[31:2], 2'b00});
        end
        if (since_rst == 0 && !redirect_valid) begin
          chk("first_req", 32'(imem_req), 32'd1);
          chk("first_addr", imem_addr, RESET_PC);
        end
        if (since_rst == 2 && !r1 && !r2) begin
          chk("boot_valid", 32'(out_valid), 32'd1);
          chk("boot_pc", out_pc, RESET_PC);
        end
        if (r1) chk("redir_bubble", 32'(out_valid), 32'd0);
        if (r2 && !r1) begin
          chk("redir_valid2", 32'(out_valid), 32'd1);
          chk("redir_pc2", out_pc, t2);
        end
        if (pv && !prdy && !pr) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_pc", out_pc, ppc);
          chk("hold_instr", out_instr, pins);
        end
        stall_run = (!out_ready && !redirect_valid) ? stall_run + 1 : 0;
        if (stall_run >= DEPTH + 1) chk("stall_req", 32'(imem_req), 32'd0);
        if (cur_pop) begin
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL scoreboard: got delivery of pc %08h expected none", out_pc);
          end else begin
            e = exp_q.pop_front();
            chk("out_pc", out_pc, e);
            chk("out_instr", out_instr, word_of(e));
            chk("out_pc_plus4", out_pc_plus4, e + 32'd4);
            delivered++;
          end
        end
        pend_valid = imem_req;
        pend_addr  = imem_addr;
        r2 = r1; r1 = redirect_valid;
        t2 = t1; t1 = {redirect_pc[31:2], 2'b00};
        pv = out_valid; prdy = out_ready; pr = redirect_valid;
        ppc = out_pc; pins = out_instr;
      end
    end
  end

  // Stimulus: directed scenarios followed by a randomized run
  initial begin : stimulus
    int stall_left;
    logic rdy, rv;
    logic [31:0] rpc;
    restart(RESET_PC);
    topup();
    for (int i = 0; i < 3; i++) drive(0, 1, 0, '0);
    // boot stream, then 5-cycle stall from cycle 2, then release
    for (int i = 0; i < 2; i++) drive(1, 1, 0, '0);
    for (int i = 0; i < 5; i++) drive(1, 0, 0, '0);
    for (int i = 0; i < 4; i++) drive(1, 1, 0, '0);
    drive(1, 1, 1, 32'h0000_1000);
    for (int i = 0; i < 4; i++) drive(1, 1, 0, '0);
    // fill the FIFO, then redirect with ready high to an unaligned target
    for (int i = 0; i < 4; i++) drive(1, 0, 0, '0);
    drive(1, 1, 1, 32'h0000_2003);
    for (int i = 0; i < 4; i++) drive(1, 1, 0, '0);
    // back-to-back redirects
    drive(1, 1, 1, 32'h0000_0100);
    drive(1, 1, 1, 32'h0000_0200);
    for (int i = 0; i < 5; i++) drive(1, 1, 0, '0);
    // address wrap, then reset mid-stream
    drive(1, 1, 1, 32'hFFFF_FFFC);
    for (int i = 0; i < 5; i++) drive(1, 1, 0, '0);
    drive(0, 1, 0, '0);
    drive(0, 1, 0, '0);
    for (int i = 0; i < 6; i++) drive(1, 1, 0, '0);

    stall_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) < 3) begin
        drive(0, 1, 0, '0);
        if ($urandom_range(0, 1) == 1) drive(0, 0, 0, '0);
        continue;
      end
      if (stall_left == 0 && $urandom_range(0, 49) == 0) stall_left = $urandom_range(3, 8);
      if (stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end else begin
        rdy = ($urandom_range(0, 3) != 0);
      end
      rv = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        1:       rpc = 32'($urandom_range(0, 255));
        default: rpc = $urandom();
      endcase
      drive(1, rdy, rv, rpc);
    end
    for (int i = 0; i < 4; i++) drive(1, 1, 0, '0);
    @(posedge clk);
    #1;
    chk("delivered_min", 32'(delivered >= 1000), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage that produces the instruction stream consumed by the decode stage. Owns the program counter, issues word reads to a fixed-latency instruction memory, and buffers returned words in a small FIFO. Presents {instruction, PC, PC+4} to decode with a valid/ready handshake. Accepts taken-branch/jump redirects from execute and discards wrong-path words.

## Interface
- RESET_PC, 32'hBFC0_0000, first fetch address after reset
- DEPTH, 2, output FIFO entries (power of two, ≥2)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- redirect_valid  in  1  execute requests PC change (taken branch, jal, jalr)
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 0)
- imem_req  out  1  read request this cycle (always accepted)
- imem_addr  out  32  word-aligned read address, valid when imem_req=1
- imem_rdata  in  32  read data, valid exactly 1 cycle after the request
- out_valid  out  1  FIFO head holds a valid instruction
- out_ready  in  1  decode accepts head this cycle
- out_instr  out  32  instruction word
- out_pc  out  32  address of out_instr
- out_pc_plus4  out  32  out_pc + 4, modulo 2^32

## Operation
- State: fetch PC register `pc`, in-flight flag + in-flight PC, FIFO (DEPTH × {instr, pc}), read/write pointers, occupancy count (0..DEPTH).
- Reset (rst_n=0, async): pc=RESET_PC, FIFO empty, in-flight cleared. Outputs: imem_req=0, out_valid=0, out_instr=0, out_pc=0, out_pc_plus4=0 held while reset asserted.
- pop = out_valid & out_ready & ~redirect_valid.
- Issue rule (no redirect): imem_req=1 iff occupancy + inflight − pop < DEPTH. imem_addr=pc; on issue pc<=pc+4 (wraps 32'hFFFF_FFFC → 0), in-flight set with its PC.
- Response: cycle after an issue, {imem_rdata, in-flight PC} is written at FIFO tail unless dropped (below). Never overflows by the issue rule.
- Head: out_valid = (occupancy≠0); out_instr/out_pc from head entry (registered; no bypass from imem_rdata). out_pc_plus4 = out_pc+4.
- Redirect (redirect_valid=1 in cycle N):
  - FIFO flushed (occupancy←0), pop ignored even if out_ready=1.
  - Response arriving in cycle N (from request in N−1) is dropped.
  - imem_req=1, imem_addr={redirect_pc[31:2],2'b00} in cycle N; pc<=that+4.
  - Back-to-back redirects: each cycle's redirect wins; only the last one's stream survives.
- Stall: out_ready=0 with FIFO full → imem_req=0, pc held, head held stable (out_instr/out_pc unchanged while out_valid & ~out_ready).
- out_valid never falls without a pop or a redirect.

## Timing
- Request-to-output latency 2 cycles: request in N, data at FIFO write edge end of N+1, out_valid in N+2.
- Reset release: first request in first cycle with rst_n=1 (cycle 0, addr RESET_PC); out_valid=1 in cycle 2.
- Redirect in N → out_valid=0 in N+1, first redirected word valid in N+2.
- Steady state with out_ready=1: one instruction per cycle, PCs consecutive +4.
- imem_req depends combinationally on out_ready and redirect_valid; no other comb input→output paths except imem_addr from redirect_pc.
- Reset asserted mid-operation: all state cleared immediately, in-flight response ignored; restart at RESET_PC.

## Test plan
- Reset, out_ready=1, imem returns addr-derived words → out_pc 0xBFC00000 at cycle 2, then 0xBFC00004, 0xBFC00008… one per cycle, out_pc_plus4 = out_pc+4.
- Hold out_ready=0 from cycle 2 for 5 cycles → exactly DEPTH words buffered, imem_req=0 after fill, head stays 0xBFC00000; release → words in order, no gaps/duplicates.
- Redirect to 0x00001000 at cycle 6 with out_ready=1 → out_valid=0 in cycle 7, out_pc=0x00001000 in cycle 8, none of 0xBFC000xx after cycle 6 delivered.
- Redirect to 0x00002003 while FIFO full and out_ready=1 → no pop that cycle, imem_addr=0x00002000, next delivered out_pc=0x00002000.
- Redirects in consecutive cycles to 0x100 then 0x200 → only 0x200, 0x204… delivered.
- Redirect to 0xFFFFFFFC → out_pc 0xFFFFFFFC then 0x00000000, out_pc_plus4 0x00000000 then 0x00000004; assert rst_n=0 mid-stream → out_valid=0 immediately, restart at RESET_PC.
